// File: rtl/softex_tcdm_splitter.sv
// softex_tcdm_splitter
// Takes one wide HCI request and issues it as MP 32-bit TCDM requests. Narrow
// grants may arrive in any cycle; a grant mask tracks which ports are done.
// Narrow read responses are queued per port and merged into one wide response
// once every port has data. A credit counter caps outstanding wide reads at DEPTH.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   wide_req_i/gnt_o       wide request handshake (gnt is combinational in IDLE)
//   wide_add_i/wen_i/be_i/data_i/id_i   wide request payload (wen=1 means read)
//   wide_r_valid_o/ready_i wide response handshake
//   wide_r_data_o/id_o     reassembled read data and its transaction ID
//   tcdm_req_o/gnt_i       per-port narrow request handshake
//   tcdm_add_o/wen_o/be_o/data_o        per-port narrow payload (registered)
//   tcdm_r_ready_o         per-port response ready, always 1
//   tcdm_r_valid_i/data_i  per-port narrow read response
//   busy_o                 request in flight or reads outstanding
module softex_tcdm_splitter #(
  parameter int unsigned MP    = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned IW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DW   = MP * 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wide_req_i,
  output logic             wide_gnt_o,
  input  logic [AW-1:0]    wide_add_i,
  input  logic             wide_wen_i,
  input  logic [DW/8-1:0]  wide_be_i,
  input  logic [DW-1:0]    wide_data_i,
  input  logic [IW-1:0]    wide_id_i,
  output logic             wide_r_valid_o,
  input  logic             wide_r_ready_i,
  output logic [DW-1:0]    wide_r_data_o,
  output logic [IW-1:0]    wide_r_id_o,
  output logic [MP-1:0]    tcdm_req_o,
  input  logic [MP-1:0]    tcdm_gnt_i,
  output logic [MP*32-1:0] tcdm_add_o,
  output logic [MP-1:0]    tcdm_wen_o,
  output logic [MP*4-1:0]  tcdm_be_o,
  output logic [MP*32-1:0] tcdm_data_o,
  output logic [MP-1:0]    tcdm_r_ready_o,
  input  logic [MP-1:0]    tcdm_r_valid_i,
  input  logic [MP*32-1:0] tcdm_r_data_i,
  output logic             busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);      // FIFO index width
  localparam int unsigned CW = $clog2(DEPTH + 1);  // credit counter width
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW:0]   PTR_ONE = (PW + 1)'(1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  state_e            state_q, state_d;
  logic [MP-1:0]     mask_q, mask_d;
  logic [MP-1:0]     granted;
  logic [AW-1:0]     add_q;
  logic              wen_q;
  logic [DW/8-1:0]   be_q;
  logic [DW-1:0]     data_q;
  logic [CW-1:0]     cnt_q;
  logic              rd_accept;
  logic              pop;
  logic [MP-1:0]     port_valid;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    mask_d     = mask_q;
    wide_gnt_o = 1'b0;
    tcdm_req_o = '0;
    granted    = '0;
    case (state_q)
      IDLE: begin
        // Writes never consume a credit, so they are accepted even when full.
        wide_gnt_o = wide_req_i & (~wide_wen_i | (cnt_q < CNT_MAX));
        if (wide_gnt_o) state_d = ISSUE;
      end
      ISSUE: begin
        tcdm_req_o = ~mask_q;
        granted    = tcdm_req_o & tcdm_gnt_i;
        if ((mask_q | granted) == {MP{1'b1}}) begin
          mask_d  = '0;
          state_d = IDLE;
        end else begin
          mask_d = mask_q | granted;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_accept      = wide_gnt_o & wide_wen_i;
  assign pop            = wide_r_valid_o & wide_r_ready_i;
  assign wide_r_valid_o = &port_valid;
  assign busy_o         = (state_q != IDLE) | (cnt_q != '0);
  assign tcdm_r_ready_o = '1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      add_q   <= '0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (wide_gnt_o) begin
        add_q  <= wide_add_i;
        wen_q  <= wide_wen_i;
        be_q   <= wide_be_i;
        data_q <= wide_data_i;
      end
      case ({rd_accept, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ID FIFO: one entry per accepted read, popped with the wide response
  // ---------------------------------------------------------------------------
  logic [IW-1:0] id_mem [DEPTH];
  logic [PW:0]   id_wptr, id_rptr;
  logic          id_full;

  assign id_full     = (id_wptr[PW] != id_rptr[PW]) && (id_wptr[PW-1:0] == id_rptr[PW-1:0]);
  assign wide_r_id_o = id_mem[id_rptr[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_wptr <= '0;
      id_rptr <= '0;
    end else begin
      if (rd_accept) id_wptr <= id_wptr + PTR_ONE;
      if (pop)       id_rptr <= id_rptr + PTR_ONE;
    end
  end

  // NOTE: FIFO storage is not reset; the cleared pointers mark it empty, so
  // stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (rd_accept) id_mem[id_wptr[PW-1:0]] <= wide_id_i;
  end

  a_id_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(rd_accept && id_full));

  // ---------------------------------------------------------------------------
  // Per-port narrow payload and response FIFO
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < MP; i++) begin : g_port
    logic [31:0]   mem [DEPTH];
    logic [PW:0]   wptr, rptr;
    logic [CW-1:0] pend;   // narrow reads granted on this port, response not yet seen
    logic          push;
    logic          rd_granted;
    logic          full;
    logic [AW-1:0] port_add;

    assign port_add                 = add_q + AW'(4 * i);
    assign tcdm_add_o[i*32 +: 32]   = 32'(port_add);
    assign tcdm_wen_o[i]            = wen_q;
    assign tcdm_be_o[i*4 +: 4]      = be_q[i*4 +: 4];
    assign tcdm_data_o[i*32 +: 32]  = data_q[i*32 +: 32];

    // Responses are only accepted while this port owes read data; write
    // responses and anything arriving after a reset find pend==0 and are dropped.
    assign rd_granted = granted[i] & wen_q;
    assign push       = tcdm_r_valid_i[i] & (pend != '0);
    assign full       = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

    assign port_valid[i]             = (wptr != rptr);
    assign wide_r_data_o[i*32 +: 32] = mem[rptr[PW-1:0]];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wptr <= '0;
        rptr <= '0;
        pend <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
        case ({rd_granted, push})
          2'b10:   pend <= pend + CNT_ONE;
          2'b01:   pend <= pend - CNT_ONE;
          default: pend <= pend;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem[wptr[PW-1:0]] <= tcdm_r_data_i[i*32 +: 32];
    end

    a_port_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  end

endmodule

// File: tb/tb_softex_tcdm_splitter.sv
// Directed bench for softex_tcdm_splitter. Expected wide responses are pushed to
// a scoreboard queue when a read is issued and compared when the DUT returns them.
module tb_softex_tcdm_splitter;

  localparam int MP    = 4;
  localparam int AW    = 32;
  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = MP * 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             wide_req_i = 1'b0;
  logic             wide_gnt_o;
  logic [AW-1:0]    wide_add_i = '0;
  logic             wide_wen_i = 1'b0;
  logic [DW/8-1:0]  wide_be_i = '0;
  logic [DW-1:0]    wide_data_i = '0;
  logic [IW-1:0]    wide_id_i = '0;
  logic             wide_r_valid_o;
  logic             wide_r_ready_i = 1'b0;
  logic [DW-1:0]    wide_r_data_o;
  logic [IW-1:0]    wide_r_id_o;
  logic [MP-1:0]    tcdm_req_o;
  logic [MP-1:0]    tcdm_gnt_i = '0;
  logic [MP*32-1:0] tcdm_add_o;
  logic [MP-1:0]    tcdm_wen_o;
  logic [MP*4-1:0]  tcdm_be_o;
  logic [MP*32-1:0] tcdm_data_o;
  logic [MP-1:0]    tcdm_r_ready_o;
  logic [MP-1:0]    tcdm_r_valid_i = '0;
  logic [MP*32-1:0] tcdm_r_data_i = '0;
  logic             busy_o;

  softex_tcdm_splitter #(.MP(MP), .AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wide_req_i     (wide_req_i),
    .wide_gnt_o     (wide_gnt_o),
    .wide_add_i     (wide_add_i),
    .wide_wen_i     (wide_wen_i),
    .wide_be_i      (wide_be_i),
    .wide_data_i    (wide_data_i),
    .wide_id_i      (wide_id_i),
    .wide_r_valid_o (wide_r_valid_o),
    .wide_r_ready_i (wide_r_ready_i),
    .wide_r_data_o  (wide_r_data_o),
    .wide_r_id_o    (wide_r_id_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_wen_o     (tcdm_wen_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_ready_o (tcdm_r_ready_o),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [IW-1:0] id);
    logic [DW-1:0] d;
    for (int i = 0; i < MP; i++) d[i*32 +: 32] = {id, 8'(i), 16'hC0DE};
    return d;
  endfunction

  // Compare the wide response head with the scoreboard front, then pop it.
  task automatic pop_expect();
    exp_t e;
    int   n = 0;
    while (wide_r_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rsp_valid", 128'(wide_r_valid_o), 128'(1'b1));
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL sb_empty: observed response id 0x%0h with no expected entry", wide_r_id_o);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_data", wide_r_data_o, e.data);
      check("rsp_id", 128'(wide_r_id_o), 128'(e.id));
    end
    wide_r_ready_i = 1'b1;
    tick();
    wide_r_ready_i = 1'b0;
  endtask

  // Accept one wide read, grant all ports in the first ISSUE cycle, then
  // optionally return narrow data after `gap` idle cycles. With pop_head set,
  // the current response head is popped in the same cycle the read is accepted.
  task automatic issue_read(input logic [31:0] a, input logic [IW-1:0] id,
                            input logic [DW-1:0] rdata, input int gap,
                            input bit resp, input bit pop_head);
    exp_t e;
    wide_req_i  = 1'b1;
    wide_wen_i  = 1'b1;
    wide_add_i  = a;
    wide_id_i   = id;
    wide_be_i   = '1;
    wide_data_i = '0;
    if (pop_head) begin
      check("pop_head_valid", 128'(wide_r_valid_o), 128'(1'b1));
      e = sb.pop_front();
      check("pop_head_id", 128'(wide_r_id_o), 128'(e.id));
      wide_r_ready_i = 1'b1;
    end
    sb.push_back('{data: rdata, id: id});
    #1;
    check("rd_gnt", 128'(wide_gnt_o), 128'(1'b1));
    tick();
    wide_r_ready_i = 1'b0;
    wide_req_i     = 1'b0;
    tcdm_gnt_i     = '1;
    #1;
    check("rd_req", 128'(tcdm_req_o), 128'(4'hF));
    check("rd_add", tcdm_add_o, {a + 32'd12, a + 32'd8, a + 32'd4, a});
    tick();
    tcdm_gnt_i = '0;
    if (resp) begin
      repeat (gap) tick();
      tcdm_r_valid_i = '1;
      tcdm_r_data_i  = rdata;
      tick();
      tcdm_r_valid_i = '0;
      tcdm_r_data_i  = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_req", 128'(tcdm_req_o), 128'(4'h0));
    check("rst_valid", 128'(wide_r_valid_o), 128'(1'b0));
    check("rst_busy", 128'(busy_o), 128'(1'b0));
    check("rst_rready", 128'(tcdm_r_ready_o), 128'(4'hF));

    // 1: basic read, responses two cycles after the grant cycle
    issue_read(32'h100, 8'h5A, 128'h44444444_33333333_22222222_11111111, 1, 1'b1, 1'b0);
    pop_expect();
    #1;
    check("t1_busy_after_pop", 128'(busy_o), 128'(1'b0));
    check("t1_valid_after_pop", 128'(wide_r_valid_o), 128'(1'b0));

    // 2: staggered narrow grants on a write
    tick();
    wide_req_i  = 1'b1;
    wide_wen_i  = 1'b0;
    wide_add_i  = 32'h300;
    wide_be_i   = '1;
    wide_data_i = 128'hA;
    #1;
    check("t2_accept", 128'(wide_gnt_o), 128'(1'b1));
    tick();                     // c1
    tcdm_gnt_i = 4'b0001;
    #1;
    check("t2_c1_req", 128'(tcdm_req_o), 128'(4'b1111));
    check("t2_c1_gnt", 128'(wide_gnt_o), 128'(1'b0));
    tick();                     // c2
    tcdm_gnt_i = 4'b0100;
    #1;
    check("t2_c2_req", 128'(tcdm_req_o), 128'(4'b1110));
    check("t2_c2_gnt", 128'(wide_gnt_o), 128'(1'b0));
    tick();                     // c3
    tcdm_gnt_i = 4'b0000;
    #1;
    check("t2_c3_req", 128'(tcdm_req_o), 128'(4'b1010));
    check("t2_c3_gnt", 128'(wide_gnt_o), 128'(1'b0));
    tick();                     // c4
    tcdm_gnt_i = 4'b1010;
    #1;
    check("t2_c4_req", 128'(tcdm_req_o), 128'(4'b1010));
    check("t2_c4_gnt", 128'(wide_gnt_o), 128'(1'b0));
    tick();                     // c5: back in IDLE
    tcdm_gnt_i = '0;
    wide_req_i = 1'b0;
    #1;
    check("t2_c5_req", 128'(tcdm_req_o), 128'(4'b0000));
    check("t2_c5_busy", 128'(busy_o), 128'(1'b0));

    // 3: credit limit
    tick();
    for (int k = 1; k <= 4; k++)
      issue_read(32'h1000 + 32'(k) * 32'h10, 8'(k), mk_data(8'(k)), 0, 1'b1, 1'b0);
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_id_i  = 8'h05;
    #1;
    check("t3_read_refused", 128'(wide_gnt_o), 128'(1'b0));
    wide_wen_i = 1'b0;
    #1;
    check("t3_write_granted", 128'(wide_gnt_o), 128'(1'b1));
    tick();
    wide_req_i = 1'b0;
    tcdm_gnt_i = '1;
    #1;
    check("t3_write_wen", 128'(tcdm_wen_o), 128'(4'h0));
    tick();
    tcdm_gnt_i = '0;
    pop_expect();                                              // id 1, cnt 3
    issue_read(32'h2000, 8'h05, mk_data(8'h05), 0, 1'b1, 1'b1); // pops id 2, cnt stays 3
    issue_read(32'h2010, 8'h06, mk_data(8'h06), 0, 1'b1, 1'b0); // cnt 4
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_id_i  = 8'h07;
    #1;
    check("t3_full_again", 128'(wide_gnt_o), 128'(1'b0));
    wide_req_i = 1'b0;
    repeat (4) pop_expect();                                   // ids 3,4,5,6
    #1;
    check("t3_busy_drained", 128'(busy_o), 128'(1'b0));

    // 4: backpressure holds the head stable
    for (int k = 1; k <= 3; k++)
      issue_read(32'h3000, 8'(k), mk_data(8'(k)) ^ {4{32'hFFFF0000}}, 0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_valid", 128'(wide_r_valid_o), 128'(1'b1));
      check("t4_hold_data", wide_r_data_o, sb[0].data);
      check("t4_hold_id", 128'(wide_r_id_o), 128'(8'h01));
    end
    repeat (3) pop_expect();

    // 5: write with partial byte enables; narrow write responses are ignored
    wide_req_i  = 1'b1;
    wide_wen_i  = 1'b0;
    wide_add_i  = 32'h400;
    wide_be_i   = 16'h00F0;
    wide_data_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    #1;
    check("t5_accept", 128'(wide_gnt_o), 128'(1'b1));
    tick();
    wide_req_i = 1'b0;
    tcdm_gnt_i = '1;
    #1;
    check("t5_be", 128'(tcdm_be_o), 128'(16'h00F0));
    check("t5_data", tcdm_data_o, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    check("t5_add", tcdm_add_o, 128'h0000040C_00000408_00000404_00000400);
    tick();
    tcdm_gnt_i     = '0;
    tcdm_r_valid_i = '1;
    tcdm_r_data_i  = '1;
    tick();
    tcdm_r_valid_i = '0;
    tcdm_r_data_i  = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_no_rsp", 128'(wide_r_valid_o), 128'(1'b0));
      check("t5_busy", 128'(busy_o), 128'(1'b0));
    end

    // 6: reset during ISSUE with two reads outstanding
    issue_read(32'h500, 8'h31, mk_data(8'h31), 0, 1'b0, 1'b0);
    issue_read(32'h510, 8'h32, mk_data(8'h32), 0, 1'b0, 1'b0);
    wide_req_i = 1'b1;
    wide_wen_i = 1'b1;
    wide_add_i = 32'h520;
    wide_id_i  = 8'h33;
    #1;
    check("t6_accept", 128'(wide_gnt_o), 128'(1'b1));
    tick();
    wide_req_i = 1'b0;
    #1;
    check("t6_issue_req", 128'(tcdm_req_o), 128'(4'hF));
    check("t6_busy", 128'(busy_o), 128'(1'b1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sb.delete();
    #1;
    check("t6_req_cleared", 128'(tcdm_req_o), 128'(4'h0));
    check("t6_valid_cleared", 128'(wide_r_valid_o), 128'(1'b0));
    check("t6_busy_cleared", 128'(busy_o), 128'(1'b0));
    tcdm_r_valid_i = '1;
    tcdm_r_data_i  = 128'h99;
    tick();
    tcdm_r_valid_i = '0;
    tcdm_r_data_i  = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_late_dropped", 128'(wide_r_valid_o), 128'(1'b0));
    end
    issue_read(32'h600, 8'h40, mk_data(8'h40), 0, 1'b1, 1'b0);
    pop_expect();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
